// File: rtl/mesa_hex2bin.sv
// ASCII hex-pair to binary byte packer with newline-delimited packets and error counting.
// Build option: define MESA_HEX2BIN_LOWER_EN to also accept lowercase a-f as hex digits.
module mesa_hex2bin (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_rdy,
  input  logic       baud_lock,
  output logic [7:0] dout,
  output logic       dout_rdy,
  output logic       dout_sop,
  output logic       dout_eop,
  output logic       pkt_active,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HI_NIB = 2'd1,
    LO_NIB = 2'd2
  } state_t;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_NL    = 8'h0A;

  state_t     state_q;
  logic [3:0] hi_nib_q;
  logic [7:0] dout_q;
  logic       dout_rdy_q;
  logic       dout_sop_q;
  logic       dout_eop_q;
  logic       pkt_active_q;
  logic [7:0] err_cnt_q;

  logic       is_hex;
  logic [3:0] hex_val;
  logic       is_space;
  logic       is_nl;
  logic       err_inc;

  // Character classification.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    is_hex  = 1'b0;
    hex_val = 4'h0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_hex  = 1'b1;
      hex_val = rx_byte[3:0];
    end else if (rx_byte >= 8'h41 && rx_byte <= 8'h46) begin
      is_hex  = 1'b1;
      hex_val = rx_byte[3:0] + 4'd9;
    end
`ifdef MESA_HEX2BIN_LOWER_EN
    else if (rx_byte >= 8'h61 && rx_byte <= 8'h66) begin
      is_hex  = 1'b1;
      hex_val = rx_byte[3:0] + 4'd9;
    end
`endif
    is_space = (rx_byte == CHAR_SPACE);
    is_nl    = (rx_byte == CHAR_NL);
  end

  // Losing lock mid-packet counts as one error; pkt_active drops so it counts once.
  always_comb begin
    err_inc = 1'b0;
    if (!baud_lock) begin
      err_inc = pkt_active_q;
    end else if (rx_rdy) begin
      unique case (state_q)
        IDLE, HI_NIB: err_inc = !is_hex && !is_space && !is_nl;
        LO_NIB:       err_inc = !is_hex;
        default:      err_inc = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hi_nib_q     <= 4'h0;
      dout_q       <= 8'h00;
      dout_rdy_q   <= 1'b0;
      dout_sop_q   <= 1'b0;
      dout_eop_q   <= 1'b0;
      pkt_active_q <= 1'b0;
      err_cnt_q    <= 8'h00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      dout_rdy_q <= 1'b0;
      dout_sop_q <= 1'b0;
      dout_eop_q <= 1'b0;

      if (err_inc && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end

      if (!baud_lock) begin
        state_q      <= IDLE;
        hi_nib_q     <= 4'h0;
        pkt_active_q <= 1'b0;
      end else if (rx_rdy) begin
        unique case (state_q)
          IDLE, HI_NIB: begin
            if (is_hex) begin
              hi_nib_q <= hex_val;
              state_q  <= LO_NIB;
            end else if (is_nl) begin
              dout_eop_q   <= pkt_active_q;
              pkt_active_q <= 1'b0;
              state_q      <= IDLE;
            end
          end
          LO_NIB: begin
            hi_nib_q <= 4'h0;
            if (is_hex) begin
              dout_q       <= {hi_nib_q, hex_val};
              dout_rdy_q   <= 1'b1;
              dout_sop_q   <= !pkt_active_q;
              pkt_active_q <= 1'b1;
              state_q      <= HI_NIB;
            end else if (is_nl) begin
              dout_eop_q   <= pkt_active_q;
              pkt_active_q <= 1'b0;
              state_q      <= IDLE;
            end else begin
              state_q <= pkt_active_q ? HI_NIB : IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_rdy   = dout_rdy_q;
  assign dout_sop   = dout_sop_q;
  assign dout_eop   = dout_eop_q;
  assign pkt_active = pkt_active_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: doc/mesa_hex2bin.md
MESA_HEX2BIN -- requirements
Module: mesa_hex2bin

Interface
REQ-001 The block SHALL use clock `clk`; reset is `reset`, synchronous, active-high.
REQ-002 Port list SHALL be:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- rx_byte  input  8  ASCII character from the UART receiver
- rx_rdy  input  1  single-cycle strobe, rx_byte valid
- baud_lock  input  1  UART baud lock; low means the character stream is untrusted
- dout  output  8  packed binary byte
- dout_rdy  output  1  single-cycle strobe, dout valid
- dout_sop  output  1  high with dout_rdy on the first byte of a packet
- dout_eop  output  1  single-cycle end-of-packet pulse
- pkt_active  output  1  high between first byte and end of packet
- err_cnt  output  8  saturating count of malformed characters

Function
REQ-003 The block SHALL have three states: IDLE, HI_NIB and LO_NIB.
REQ-004 Hex digit set: 0x30-0x39 (0-9) and 0x41-0x46 (A-F), mapped to nibble values 0-15.
REQ-005 A character SHALL be consumed only on a cycle with rx_rdy=1 and baud_lock=1; all other rx_byte values are ignored.
REQ-006 IDLE:
- hex digit -> store high nibble, go to LO_NIB
- 0x20 (space) or 0x0A (newline) -> stay in IDLE, no output
- any other character -> increment err_cnt, stay in IDLE
REQ-007 HI_NIB:
- hex digit -> store high nibble, go to LO_NIB
- space -> ignored
- newline -> end packet (REQ-010), go to IDLE
- other -> increment err_cnt
REQ-008 LO_NIB:
- hex digit -> next cycle, dout = {high, low} with dout_rdy=1; go to HI_NIB
- newline -> discard the half byte, increment err_cnt, end packet, go to IDLE
- any other character (including space) -> discard the half byte, increment err_cnt, go to HI_NIB (or to IDLE if no byte has yet been emitted in the current packet)
REQ-009 dout_rdy latency SHALL be exactly 1 clk after the rx_rdy of the low-nibble character; dout SHALL hold its value until the next dout_rdy.
REQ-010 End of packet:
- if at least one byte has been emitted since the last SOP, dout_eop SHALL pulse for 1 cycle, 1 clk after the newline rx_rdy, and pkt_active SHALL drop on that same cycle
- otherwise no dout_eop SHALL be generated
REQ-011 pkt_active SHALL rise on the cycle of the first dout_rdy of a packet; dout_sop SHALL be high only on that cycle.
REQ-012 err_cnt SHALL saturate at 0xFF and never wrap.
REQ-013 baud_lock low for any cycle SHALL:
- force the state to IDLE and drop any partial nibble
- force pkt_active=0
- emit no dout_eop
- if a packet was active, increment err_cnt once
REQ-014 A newline with rx_rdy on the same cycle that baud_lock falls SHALL be ignored (REQ-005 governs).
REQ-015 Back-to-back rx_rdy on consecutive cycles SHALL be accepted without loss.

Reset
REQ-016 On reset:
- state = IDLE
- dout = 0x00
- dout_rdy = dout_sop = dout_eop = pkt_active = 0
- err_cnt = 0x00
- stored nibble = 0
REQ-017 Reset asserted mid-packet SHALL abort the packet with no dout_eop and no err_cnt increment.

Configuration
REQ-018 The macro SHALL be MESA_HEX2BIN_LOWER_EN.
- defined: 0x61-0x66 (a-f) are also hex digits, values 10-15
- undefined: 0x61-0x66 are non-hex characters and are handled as "other" in every state

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- baud_lock=1, send "A5 3C\n" -> dout_rdy with 0xA5 (sop=1), then 0x3C (sop=0); dout_eop 1 clk after the newline; err_cnt=0.
- send "4G2\n" -> "G" arrives in LO_NIB: err_cnt=1, no byte emitted, state returns to IDLE; "2" then newline -> err_cnt=2; no dout_rdy and no dout_eop.
- send "1f\n" -> with MESA_HEX2BIN_LOWER_EN defined: dout=0x1F; undefined: err_cnt=1, no output.
- send "12" then drop baud_lock for 1 cycle, then "34\n" -> one byte 0x12; then 0x34 with sop=1; exactly one dout_eop; err_cnt=1.
- send 300 "Z" characters -> err_cnt=0xFF (saturated).
- send "AB" on consecutive-cycle rx_rdy, then assert reset during "C" -> dout=0xAB emitted; after reset all outputs = 0, err_cnt=0.
